// File: rtl/dem_gpg_timer_if.sv
// Signal bundle between the enable generator / control panel (master) and the
// dem_gpg_timer counter (slave); field values flow back to the display formatter.
interface dem_gpg_timer_if #(
    parameter int W = 7
);
    // Strobe semantics: ena_tick, ena5hz, start, stop and clr are single-cycle
    // pulses sampled on the falling clock edge; there is no ready/backpressure,
    // the timer consumes every strobe on the edge it is seen. ena_up, ena_dw,
    // gt_mod and dir are levels sampled on the same edge.
    logic         ena_tick;
    logic         ena5hz;
    logic         ena_up;
    logic         ena_dw;
    logic [1:0]   gt_mod;
    logic         dir;
    logic         start;
    logic         stop;
    logic         clr;
    logic [W-1:0] ptgiay;
    logic [W-1:0] giay;
    logic [W-1:0] phut;
    logic [W-1:0] gio;
    logic         done;
    logic [1:0]   state;

    modport master (
        output ena_tick, ena5hz, ena_up, ena_dw, gt_mod, dir, start, stop, clr,
        input  ptgiay, giay, phut, gio, done, state
    );

    modport slave (
        input  ena_tick, ena5hz, ena_up, ena_dw, gt_mod, dir, start, stop, clr,
        output ptgiay, giay, phut, gio, done, state
    );
endinterface

// File: rtl/dem_gpg_timer.sv
// Up/down stopwatch-timer with hundredths/seconds/minutes/hours fields,
// per-field adjust and a STOP/RUN/DONE control FSM; all state moves on the falling edge.
module dem_gpg_timer #(
    parameter int SUB_MOD  = 100,
    parameter int HOUR_MOD = 24,
    parameter int W        = 7
) (
    input  logic             i_ckht,
    input  logic             i_rst,
    dem_gpg_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [W-1:0] L_ZERO     = '0;
    localparam logic [W-1:0] L_ONE      = W'(1);
    localparam logic [W-1:0] L_SUB_MAX  = W'(SUB_MOD - 1);
    localparam logic [W-1:0] L_SEC_MAX  = W'(59);
    localparam logic [W-1:0] L_HOUR_MAX = W'(HOUR_MOD - 1);

    state_t       r_state;
    logic         r_dir;
    logic [W-1:0] r_pt;
    logic [W-1:0] r_s;
    logic [W-1:0] r_m;
    logic [W-1:0] r_h;

    state_t       w_state_nx;
    logic         w_dir_nx;
    logic [W-1:0] w_pt_nx;
    logic [W-1:0] w_s_nx;
    logic [W-1:0] w_m_nx;
    logic [W-1:0] w_h_nx;

    logic [W-1:0] w_up_pt;
    logic [W-1:0] w_up_s;
    logic [W-1:0] w_up_m;
    logic [W-1:0] w_up_h;
    logic [W-1:0] w_dn_pt;
    logic [W-1:0] w_dn_s;
    logic [W-1:0] w_dn_m;
    logic [W-1:0] w_dn_h;
    logic [W-1:0] w_adj_pt;
    logic [W-1:0] w_adj_s;
    logic [W-1:0] w_adj_m;
    logic [W-1:0] w_adj_h;

    logic w_all_zero;
    logic w_dn_zero;
    logic w_adj_req;

    assign w_all_zero = (r_pt == L_ZERO) && (r_s == L_ZERO) &&
                        (r_m == L_ZERO) && (r_h == L_ZERO);
    assign w_dn_zero  = (w_dn_pt == L_ZERO) && (w_dn_s == L_ZERO) &&
                        (w_dn_m == L_ZERO) && (w_dn_h == L_ZERO);
    assign w_adj_req  = bus.ena5hz && (bus.gt_mod != 2'b00) &&
                        (bus.ena_up || bus.ena_dw);

    // Count-up carry cascade: each field only advances when all lower fields wrap.
    always_comb begin
        w_up_pt = r_pt + L_ONE;
        w_up_s  = r_s;
        w_up_m  = r_m;
        w_up_h  = r_h;
        if (r_pt == L_SUB_MAX) begin
            w_up_pt = L_ZERO;
            w_up_s  = r_s + L_ONE;
            if (r_s == L_SEC_MAX) begin
                w_up_s = L_ZERO;
                w_up_m = r_m + L_ONE;
                if (r_m == L_SEC_MAX) begin
                    w_up_m = L_ZERO;
                    w_up_h = (r_h == L_HOUR_MAX) ? L_ZERO : r_h + L_ONE;
                end
            end
        end
    end

    // Count-down borrow cascade; only used when the total is non-zero, so gio never underflows.
    always_comb begin
        w_dn_pt = r_pt - L_ONE;
        w_dn_s  = r_s;
        w_dn_m  = r_m;
        w_dn_h  = r_h;
        if (r_pt == L_ZERO) begin
            w_dn_pt = L_SUB_MAX;
            w_dn_s  = r_s - L_ONE;
            if (r_s == L_ZERO) begin
                w_dn_s = L_SEC_MAX;
                w_dn_m = r_m - L_ONE;
                if (r_m == L_ZERO) begin
                    w_dn_m = L_SEC_MAX;
                    w_dn_h = r_h - L_ONE;
                end
            end
        end
    end

    // Single-field adjust with local wrap; a seconds step also re-zeroes the hundredths.
    always_comb begin
        w_adj_pt = r_pt;
        w_adj_s  = r_s;
        w_adj_m  = r_m;
        w_adj_h  = r_h;
        case (bus.gt_mod)
            2'b01: begin
                w_adj_pt = L_ZERO;
                if (bus.ena_up) begin
                    w_adj_s = (r_s == L_SEC_MAX) ? L_ZERO : r_s + L_ONE;
                end else begin
                    w_adj_s = (r_s == L_ZERO) ? L_SEC_MAX : r_s - L_ONE;
                end
            end
            2'b10: begin
                if (bus.ena_up) begin
                    w_adj_m = (r_m == L_SEC_MAX) ? L_ZERO : r_m + L_ONE;
                end else begin
                    w_adj_m = (r_m == L_ZERO) ? L_SEC_MAX : r_m - L_ONE;
                end
            end
            2'b11: begin
                if (bus.ena_up) begin
                    w_adj_h = (r_h == L_HOUR_MAX) ? L_ZERO : r_h + L_ONE;
                end else begin
                    w_adj_h = (r_h == L_ZERO) ? L_HOUR_MAX : r_h - L_ONE;
                end
            end
            default: begin
            end
        endcase
    end

    // Control FSM next state and field selection; clr > stop > start > tick.
    always_comb begin
        w_state_nx = r_state;
        w_dir_nx   = r_dir;
        w_pt_nx    = r_pt;
        w_s_nx     = r_s;
        w_m_nx     = r_m;
        w_h_nx     = r_h;
        if (bus.clr) begin
            w_state_nx = ST_STOP;
            w_pt_nx    = L_ZERO;
            w_s_nx     = L_ZERO;
            w_m_nx     = L_ZERO;
            w_h_nx     = L_ZERO;
        end else begin
            case (r_state)
                ST_STOP: begin
                    if (bus.start && !bus.stop) begin
                        w_dir_nx   = bus.dir;
                        w_state_nx = (bus.dir && w_all_zero) ? ST_DONE : ST_RUN;
                    end else if (w_adj_req) begin
                        w_pt_nx = w_adj_pt;
                        w_s_nx  = w_adj_s;
                        w_m_nx  = w_adj_m;
                        w_h_nx  = w_adj_h;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        w_state_nx = ST_STOP;
                    end else if (bus.ena_tick) begin
                        if (!r_dir) begin
                            w_pt_nx = w_up_pt;
                            w_s_nx  = w_up_s;
                            w_m_nx  = w_up_m;
                            w_h_nx  = w_up_h;
                        end else if (w_all_zero) begin
                            w_state_nx = ST_DONE;
                        end else begin
                            w_pt_nx = w_dn_pt;
                            w_s_nx  = w_dn_s;
                            w_m_nx  = w_dn_m;
                            w_h_nx  = w_dn_h;
                            if (w_dn_zero) begin
                                w_state_nx = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (w_adj_req) begin
                        w_state_nx = ST_STOP;
                        w_pt_nx    = w_adj_pt;
                        w_s_nx     = w_adj_s;
                        w_m_nx     = w_adj_m;
                        w_h_nx     = w_adj_h;
                    end
                end
                default: begin
                    w_state_nx = ST_STOP;
                end
            endcase
        end
    end

    always_ff @(negedge i_ckht or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_STOP;
            r_dir   <= 1'b0;
            r_pt    <= L_ZERO;
            r_s     <= L_ZERO;
            r_m     <= L_ZERO;
            r_h     <= L_ZERO;
        end else begin
            r_state <= w_state_nx;
            r_dir   <= w_dir_nx;
            r_pt    <= w_pt_nx;
            r_s     <= w_s_nx;
            r_m     <= w_m_nx;
            r_h     <= w_h_nx;
        end
    end

    assign bus.ptgiay = r_pt;
    assign bus.giay   = r_s;
    assign bus.phut   = r_m;
    assign bus.gio    = r_h;
    assign bus.state  = r_state;
    assign bus.done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_dem_gpg_timer.sv
// Bench for dem_gpg_timer: two parameterisations driven in lockstep, checked each
// cycle against a total-ticks model, plus literal pins on the key scenarios.
module tb_dem_gpg_timer;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    dem_gpg_timer_if #(.W(7)) bus_a ();
    dem_gpg_timer_if #(.W(7)) bus_b ();

    assign bus_b.ena_tick = bus_a.ena_tick;
    assign bus_b.ena5hz   = bus_a.ena5hz;
    assign bus_b.ena_up   = bus_a.ena_up;
    assign bus_b.ena_dw   = bus_a.ena_dw;
    assign bus_b.gt_mod   = bus_a.gt_mod;
    assign bus_b.dir      = bus_a.dir;
    assign bus_b.start    = bus_a.start;
    assign bus_b.stop     = bus_a.stop;
    assign bus_b.clr      = bus_a.clr;

    dem_gpg_timer #(.SUB_MOD(100), .HOUR_MOD(24), .W(7)) dut_a (
        .i_ckht (clk),
        .i_rst  (rst_n),
        .bus    (bus_a)
    );

    dem_gpg_timer #(.SUB_MOD(60), .HOUR_MOD(12), .W(7)) dut_b (
        .i_ckht (clk),
        .i_rst  (rst_n),
        .bus    (bus_b)
    );

    // Model: the whole time value is one integer count of sub-second ticks.
    typedef struct {
        int t;
        int st;
        bit dir;
    } model_t;

    int     sub_m[2]  = '{100, 60};
    int     hour_m[2] = '{24, 12};
    model_t mdl[2];

    function automatic int f_h(int k, int t); return t / (3600 * sub_m[k]); endfunction
    function automatic int f_m(int k, int t); return (t / (60 * sub_m[k])) % 60; endfunction
    function automatic int f_s(int k, int t); return (t / sub_m[k]) % 60; endfunction
    function automatic int f_p(int k, int t); return t % sub_m[k]; endfunction

    function automatic int adjusted(int k, int t);
        int h, m, s, p;
        h = f_h(k, t);
        m = f_m(k, t);
        s = f_s(k, t);
        p = f_p(k, t);
        if (bus_a.gt_mod == 2'd1) begin
            s = bus_a.ena_up ? (s + 1) % 60 : (s + 59) % 60;
            p = 0;
        end else if (bus_a.gt_mod == 2'd2) begin
            m = bus_a.ena_up ? (m + 1) % 60 : (m + 59) % 60;
        end else if (bus_a.gt_mod == 2'd3) begin
            h = bus_a.ena_up ? (h + 1) % hour_m[k] : (h + hour_m[k] - 1) % hour_m[k];
        end
        return ((h * 60 + m) * 60 + s) * sub_m[k] + p;
    endfunction

    function automatic model_t next_model(model_t cur, int k);
        model_t n;
        bit     adj;
        n   = cur;
        adj = bus_a.ena5hz && (bus_a.gt_mod != 2'd0) && (bus_a.ena_up || bus_a.ena_dw);
        if (bus_a.clr) begin
            n.t  = 0;
            n.st = 0;
        end else if (cur.st == 0) begin
            if (bus_a.start && !bus_a.stop) begin
                n.dir = bus_a.dir;
                n.st  = (bus_a.dir && cur.t == 0) ? 2 : 1;
            end else if (adj) begin
                n.t = adjusted(k, cur.t);
            end
        end else if (cur.st == 1) begin
            if (bus_a.stop) begin
                n.st = 0;
            end else if (bus_a.ena_tick) begin
                if (!cur.dir) begin
                    n.t = (cur.t + 1) % (hour_m[k] * 3600 * sub_m[k]);
                end else begin
                    n.t = cur.t - 1;
                    if (n.t == 0) n.st = 2;
                end
            end
        end else if (adj) begin
            n.t  = adjusted(k, cur.t);
            n.st = 0;
        end
        return n;
    endfunction

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) mdl[k] <= '{0, 0, 1'b0};
        end else begin
            for (int k = 0; k < 2; k++) mdl[k] <= next_model(mdl[k], k);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_inst(input int k, input logic [6:0] pt, input logic [6:0] s,
                            input logic [6:0] m, input logic [6:0] h,
                            input logic dn, input logic [1:0] st);
        string tg;
        tg = (k == 0) ? "a" : "b";
        chk({"model_ptgiay_", tg}, int'(pt), f_p(k, mdl[k].t));
        chk({"model_giay_", tg},   int'(s),  f_s(k, mdl[k].t));
        chk({"model_phut_", tg},   int'(m),  f_m(k, mdl[k].t));
        chk({"model_gio_", tg},    int'(h),  f_h(k, mdl[k].t));
        chk({"model_state_", tg},  int'(st), mdl[k].st);
        chk({"model_done_", tg},   int'(dn), (mdl[k].st == 2) ? 1 : 0);
    endtask

    always @(posedge clk) begin
        cmp_inst(0, bus_a.ptgiay, bus_a.giay, bus_a.phut, bus_a.gio, bus_a.done, bus_a.state);
        cmp_inst(1, bus_b.ptgiay, bus_b.giay, bus_b.phut, bus_b.gio, bus_b.done, bus_b.state);
    end

    // Literal pins, hand-computed from the scenario, independent of the model.
    task automatic pin(input string nm, input int k, input int h, input int m,
                       input int s, input int p, input int st);
        if (k == 0) begin
            chk({nm, "_gio"},    int'(bus_a.gio),    h);
            chk({nm, "_phut"},   int'(bus_a.phut),   m);
            chk({nm, "_giay"},   int'(bus_a.giay),   s);
            chk({nm, "_ptgiay"}, int'(bus_a.ptgiay), p);
            chk({nm, "_state"},  int'(bus_a.state),  st);
            chk({nm, "_done"},   int'(bus_a.done),   (st == 2) ? 1 : 0);
        end else begin
            chk({nm, "_gio"},    int'(bus_b.gio),    h);
            chk({nm, "_phut"},   int'(bus_b.phut),   m);
            chk({nm, "_giay"},   int'(bus_b.giay),   s);
            chk({nm, "_ptgiay"}, int'(bus_b.ptgiay), p);
            chk({nm, "_state"},  int'(bus_b.state),  st);
            chk({nm, "_done"},   int'(bus_b.done),   (st == 2) ? 1 : 0);
        end
    endtask

    task automatic drv(input logic tk, input logic e5, input logic up, input logic dw,
                       input logic [1:0] gm, input logic d, input logic sa,
                       input logic sp, input logic cl);
        bus_a.ena_tick = tk;
        bus_a.ena5hz   = e5;
        bus_a.ena_up   = up;
        bus_a.ena_dw   = dw;
        bus_a.gt_mod   = gm;
        bus_a.dir      = d;
        bus_a.start    = sa;
        bus_a.stop     = sp;
        bus_a.clr      = cl;
        @(posedge clk);
        bus_a.ena_tick = 1'b0;
        bus_a.ena5hz   = 1'b0;
        bus_a.ena_up   = 1'b0;
        bus_a.ena_dw   = 1'b0;
        bus_a.gt_mod   = 2'b00;
        bus_a.dir      = 1'b0;
        bus_a.start    = 1'b0;
        bus_a.stop     = 1'b0;
        bus_a.clr      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic ticks(input int n);
        repeat (n) drv(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic adj(input logic [1:0] gm, input logic up, input logic dw);
        drv(1'b0, 1'b1, up, dw, gm, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic go(input logic d);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, d, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic halt();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask
    task automatic clear();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bus_a.ena_tick = 1'b0;
        bus_a.ena5hz   = 1'b0;
        bus_a.ena_up   = 1'b0;
        bus_a.ena_dw   = 1'b0;
        bus_a.gt_mod   = 2'b00;
        bus_a.dir      = 1'b0;
        bus_a.start    = 1'b0;
        bus_a.stop     = 1'b0;
        bus_a.clr      = 1'b0;
        #1 rst_n = 1'b0;
        @(posedge clk);
        pin("reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        rst_n = 1'b1;
        idle(2);

        // Preload 23:59:59 by downward adjust, then run up through the wrap.
        adj(2'd3, 1'b0, 1'b1);
        pin("gio_dn_a", 0, 23, 0, 0, 0, 0);
        pin("gio_dn_b", 1, 11, 0, 0, 0, 0);
        adj(2'd2, 1'b0, 1'b1);
        adj(2'd1, 1'b0, 1'b1);
        pin("preload", 0, 23, 59, 59, 0, 0);
        go(1'b0);
        pin("run_up", 0, 23, 59, 59, 0, 1);
        ticks(99);
        pin("up_99", 0, 23, 59, 59, 99, 1);
        ticks(1);
        pin("up_wrap", 0, 0, 0, 0, 0, 1);

        // Countdown from one second to zero.
        halt();
        clear();
        adj(2'd1, 1'b1, 1'b0);
        pin("set_1s", 0, 0, 0, 1, 0, 0);
        go(1'b1);
        ticks(99);
        pin("dn_99", 0, 0, 0, 0, 1, 1);
        ticks(1);
        pin("dn_zero", 0, 0, 0, 0, 0, 2);
        ticks(3);
        pin("done_hold", 0, 0, 0, 0, 0, 2);
        go(1'b0);
        pin("start_in_done", 0, 0, 0, 0, 0, 2);

        // Adjust out of DONE, then borrow through every field.
        adj(2'd3, 1'b1, 1'b0);
        pin("adj_from_done", 0, 1, 0, 0, 0, 0);
        go(1'b1);
        ticks(1);
        pin("borrow_a", 0, 0, 59, 59, 99, 1);
        pin("borrow_b", 1, 0, 59, 59, 59, 1);

        // Seconds adjust wrap and up-over-down priority.
        halt();
        pin("stop_hold", 0, 0, 59, 59, 99, 0);
        adj(2'd1, 1'b1, 1'b0);
        pin("giay_up_wrap", 0, 0, 59, 0, 0, 0);
        adj(2'd1, 1'b0, 1'b1);
        pin("giay_dn_wrap", 0, 0, 59, 59, 0, 0);
        adj(2'd1, 1'b1, 1'b1);
        pin("up_priority", 0, 0, 59, 0, 0, 0);
        adj(2'd0, 1'b1, 1'b0);
        pin("gt_mod_none", 0, 0, 59, 0, 0, 0);
        drv(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        pin("no_ena5hz", 0, 0, 59, 0, 0, 0);

        // Control priority in RUN.
        go(1'b0);
        adj(2'd1, 1'b1, 1'b0);
        pin("adj_in_run", 0, 0, 59, 0, 0, 1);
        ticks(3);
        pin("run_3", 0, 0, 59, 0, 3, 1);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        pin("stop_vs_tick", 0, 0, 59, 0, 3, 0);
        clear();
        pin("clr_stop", 0, 0, 0, 0, 0, 0);
        go(1'b1);
        pin("start_dn_zero", 0, 0, 0, 0, 0, 2);
        clear();
        pin("clr_done", 0, 0, 0, 0, 0, 0);
        go(1'b0);
        ticks(5);
        pin("run_5", 0, 0, 0, 0, 5, 1);
        clear();
        pin("clr_run", 0, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a count at 00:12:34:56.
        repeat (12) adj(2'd2, 1'b1, 1'b0);
        repeat (34) adj(2'd1, 1'b1, 1'b0);
        go(1'b0);
        ticks(56);
        pin("pre_rst", 0, 0, 12, 34, 56, 1);
        #2 rst_n = 1'b0;
        #1;
        pin("async_rst_a", 0, 0, 0, 0, 0, 0);
        pin("async_rst_b", 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        rst_n = 1'b1;
        idle(3);
        pin("post_rst", 0, 0, 0, 0, 0, 0);
        go(1'b0);
        pin("restart", 0, 0, 0, 0, 0, 1);
        ticks(1);
        pin("restart_tick", 0, 0, 0, 0, 1, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
